frame_streamer: RTL and testbench
=================================

Name: frame_streamer

Overview:
- Transmit side of the convolution pixel-stream interface. Holds one IMG_W x IMG_H 8-bit frame in a local buffer.
- On command, issues a one-cycle start_signal, then streams the frame raster-order with pixel_valid/pixel_in semantics to conv_relu_top.
- Counts returning result_valid pulses, reports frame completion or a drain timeout.
- Sits between the host/loader and the conv+ReLU engine.

Parameters:
- IMG_W, 32, frame width in pixels (>=3)
- IMG_H, 32, frame height in pixels (>=3)
- PIX_W, 8, pixel width
- DRAIN_TIMEOUT, 256, max cycles in DRAIN before timeout
- ROW_GAP, 2, idle cycles between rows (used only with FRAME_STREAMER_GAP_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- load_en  in  1  write strobe into frame buffer
- load_addr  in  $clog2(IMG_W*IMG_H)  raster address y*IMG_W+x
- load_data  in  PIX_W  pixel to write
- frame_go  in  1  start transmitting the buffered frame
- start_signal  out  1  one-cycle frame-start pulse to engine
- pixel_valid  out  1  pixel_out valid this cycle
- pixel_out  out  PIX_W  pixel to engine pixel_in
- result_valid  in  1  engine result strobe (counted only)
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse, all results received
- timeout  out  1  one-cycle pulse, drain timed out
- load_err  out  1  one-cycle pulse, load_en while busy
- result_cnt  out  16  results counted for the current frame

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; all outputs 0; internal counters 0. Frame buffer contents are not cleared and are retained across reset. Reset mid-frame aborts immediately, and no done/timeout pulse is issued.
- Buffer: IMG_W*IMG_H x PIX_W, one write port, synchronous read (1-cycle latency).
- Loads:
  - accepted only in IDLE;
  - load_en while busy is dropped and load_err pulses the next cycle;
  - out-of-range load_addr is dropped silently.
- FSM states: IDLE, START, STREAM, DRAIN, DONE.
- IDLE -> START on frame_go=1. frame_go in any other state is ignored. load_en and frame_go together in IDLE: the write completes and the frame starts, and the written pixel is streamed.
- START (1 cycle):
  - start_signal=1;
  - read address 0 presented;
  - result_cnt cleared to 0.
- STREAM:
  - first pixel_valid=1 in the cycle immediately after START;
  - pixel k (k=0..IMG_W*IMG_H-1) is driven on cycle START+1+k, with back-to-back valid and no gaps;
  - pixel_out holds the last value when pixel_valid=0;
  - after the last pixel -> DRAIN, with pixel_valid=0 from the next cycle.
- Result counting: result_cnt increments on every result_valid=1 in START, STREAM or DRAIN. It is ignored in IDLE and DONE, and saturates at 16'hFFFF.
- DRAIN: exits when result_cnt reaches EXP=(IMG_W-2)*(IMG_H-2), which is 900 for 32x32.
  - If EXP is reached earlier (during STREAM), STREAM still finishes, then DRAIN lasts exactly 1 cycle.
  - If a drain cycle counter reaches DRAIN_TIMEOUT without EXP, timeout pulses for 1 cycle and the FSM returns to IDLE with no frame_done.
- DONE (1 cycle): frame_done=1, then IDLE.
- result_cnt holds its final value in IDLE until the next START.
- Latency: frame_go to first pixel_valid = 2 cycles. Total STREAM length = IMG_W*IMG_H cycles.

Optional Feature:
- Macro FRAME_STREAMER_GAP_EN.
- When defined: after each row except the last, pixel_valid=0 for exactly ROW_GAP cycles before the next row. STREAM length becomes IMG_W*IMG_H + (IMG_H-1)*ROW_GAP cycles. The engine must tolerate the gaps.
- When undefined: ROW_GAP is unused and streaming is gapless as above.

Test Plan:
- Load a vertical-edge frame (x<16 -> 0, else 255), pulse frame_go, and model the engine returning 900 result_valid pulses:
  - start_signal exactly 1 cycle, 1 cycle after frame_go;
  - exactly 1024 pixel_valid cycles contiguous, in raster order matching the loaded data;
  - frame_done one pulse;
  - result_cnt=900.
- Engine returns only 899 results: timeout pulses DRAIN_TIMEOUT=256 cycles after the last pixel, frame_done never asserts, busy=0 afterwards.
- load_en at addr 5 with data 8'hAA during STREAM: load_err pulses, and a second frame shows buffer addr 5 unchanged.
- Assert rst=0 at pixel 500, then release: next cycle all outputs 0 and state IDLE. A subsequent frame_go streams the full 1024 pixels with the checkerboard data intact.
- frame_go re-pulsed during STREAM and DRAIN: ignored, and exactly one start_signal is issued per frame.
- With FRAME_STREAMER_GAP_EN and ROW_GAP=2:
  - 31 gaps of 2 idle cycles, each after every 32nd pixel;
  - STREAM lasts 1086 cycles;
  - diagonal-line pixel order preserved.

Source files
------------

// File: rtl/frame_streamer.sv
// frame_streamer: buffers one IMG_W x IMG_H frame and streams it in raster order
// to the conv+ReLU engine, then counts the engine's results until the frame is
// complete or the drain window expires.
// Optional feature macro: FRAME_STREAMER_GAP_EN inserts ROW_GAP idle cycles
// between rows of the stream.
module frame_streamer #(
  parameter int IMG_W         = 32,
  parameter int IMG_H         = 32,
  parameter int PIX_W         = 8,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int ROW_GAP       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [$clog2(IMG_W*IMG_H)-1:0] load_addr,
  input  logic [PIX_W-1:0]               load_data,
  input  logic                           frame_go,
  output logic                           start_signal,
  output logic                           pixel_valid,
  output logic [PIX_W-1:0]               pixel_out,
  input  logic                           result_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout,
  output logic                           load_err,
  output logic [15:0]                    result_cnt
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int ADDR_W  = $clog2(NPIX);
  localparam int COL_W   = $clog2(IMG_W);
  localparam int EXP_RES = (IMG_W - 2) * (IMG_H - 2);

  // Idle cycles inserted after every row but the last; zero gives a gapless stream.
`ifdef FRAME_STREAMER_GAP_EN
  localparam int GAP_CYC = ROW_GAP;
`else
  localparam int GAP_CYC = 0 * ROW_GAP;
`endif

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [PIX_W-1:0]   mem [NPIX];
  logic [ADDR_W-1:0]  pix_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [15:0]        gap_cnt;
  logic               in_gap;
  logic [15:0]        drain_cnt;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_idx;
  logic               last_pix;
  logic               row_end;
  logic               gap_last;
  logic               got_all;
  logic               drain_last;
  logic               load_ok;

  assign last_pix   = (pix_cnt == ADDR_W'(NPIX - 1));
  assign row_end    = (GAP_CYC > 0) && (col_cnt == COL_W'(IMG_W - 1));
  assign gap_last   = (gap_cnt == 16'(GAP_CYC - 1));
  assign got_all    = (result_cnt >= 16'(EXP_RES));
  assign drain_last = (drain_cnt == 16'(DRAIN_TIMEOUT - 1));
  assign load_ok    = rst && load_en && (state == IDLE) && (32'(load_addr) < NPIX);

  // Frame buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  // Synchronous buffer read doubling as the pixel output register, so pixel_out holds between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_out <= '0;
    end else if (rd_en) begin
      pixel_out <= mem[rd_idx];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus Moore-style strobes and buffer read requests.
  always_comb begin
    next_state   = state;
    start_signal = 1'b0;
    pixel_valid  = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    timeout      = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = pix_cnt + ADDR_W'(1);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_go) begin
          next_state = START;
        end
      end
      START: begin
        start_signal = 1'b1;
        rd_en        = 1'b1;
        rd_idx       = '0;
        next_state   = STREAM;
      end
      STREAM: begin
        pixel_valid = !in_gap;
        if (in_gap) begin
          rd_en = gap_last;
        end else if (last_pix) begin
          next_state = DRAIN;
        end else begin
          rd_en = !row_end;
        end
      end
      DRAIN: begin
        if (got_all) begin
          next_state = DONE;
        end else if (drain_last) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Pixel, column, row-gap and drain counters that pace the stream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_cnt   <= '0;
      col_cnt   <= '0;
      gap_cnt   <= '0;
      in_gap    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        START: begin
          pix_cnt   <= '0;
          col_cnt   <= '0;
          gap_cnt   <= '0;
          in_gap    <= 1'b0;
          drain_cnt <= '0;
        end
        STREAM: begin
          if (in_gap) begin
            if (gap_last) begin
              in_gap  <= 1'b0;
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end else if (!last_pix) begin
            if (row_end) begin
              in_gap  <= 1'b1;
              gap_cnt <= '0;
              col_cnt <= '0;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
              col_cnt <= (col_cnt == COL_W'(IMG_W - 1)) ? '0 : col_cnt + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result counter: restarts at frame start, saturates, and freezes outside the active frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_cnt <= '0;
    end else if (state == START) begin
      result_cnt <= {15'd0, result_valid};
    end else if ((state == STREAM || state == DRAIN) && result_valid && (result_cnt != 16'hFFFF)) begin
      result_cnt <= result_cnt + 16'd1;
    end
  end

  // Flags a write attempt that arrived while a frame was in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_en && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized engine/host stimulus for frame_streamer, checked
// against a cycle-level reference model of the streaming protocol.
// Honours FRAME_STREAMER_GAP_EN so the expected pixel timing matches the build.
module tb_frame_streamer;

  localparam int IMG_W         = 32;
  localparam int IMG_H         = 32;
  localparam int PIX_W         = 8;
  localparam int DRAIN_TIMEOUT = 256;
  localparam int ROW_GAP       = 2;
  localparam int NPIX          = IMG_W * IMG_H;
  localparam int EXP_RES       = (IMG_W - 2) * (IMG_H - 2);
`ifdef FRAME_STREAMER_GAP_EN
  localparam int GAP = ROW_GAP;
`else
  localparam int GAP = 0;
`endif
  localparam int STREAM_LEN = NPIX + (IMG_H - 1) * GAP;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [9:0]        load_addr;
  logic [PIX_W-1:0]  load_data;
  logic              frame_go;
  logic              start_signal;
  logic              pixel_valid;
  logic [PIX_W-1:0]  pixel_out;
  logic              result_valid;
  logic              busy;
  logic              frame_done;
  logic              timeout;
  logic              load_err;
  logic [15:0]       result_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_res = 0;
  logic [7:0] ref_mem [NPIX];

  int         start_q[$];
  logic [7:0] pix_q[$];
  int         pixcyc_q[$];
  int         done_q[$];
  int         tout_q[$];
  int         lerr_q[$];

  frame_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .ROW_GAP(ROW_GAP)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .frame_go(frame_go), .start_signal(start_signal),
    .pixel_valid(pixel_valid), .pixel_out(pixel_out), .result_valid(result_valid),
    .busy(busy), .frame_done(frame_done), .timeout(timeout), .load_err(load_err),
    .result_cnt(result_cnt)
  );

  // Free-running clock and cycle index.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every output event with the cycle it was seen in.
  always @(negedge clk) begin
    if (start_signal) start_q.push_back(cyc);
    if (pixel_valid) begin
      pix_q.push_back(pixel_out);
      pixcyc_q.push_back(cyc);
    end
    if (frame_done) done_q.push_back(cyc);
    if (timeout) tout_q.push_back(cyc);
    if (load_err) lerr_q.push_back(cyc);
  end

  // Hard stop in case the run wedges.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: sim time exceeded, got hang, want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outVec();
    return {2'b0, start_signal, pixel_valid, busy, frame_done, timeout, load_err, pixel_out, result_cnt};
  endfunction

  // Cycle in which raster pixel k must appear, relative to the frame_go cycle.
  function automatic int pixCycle(input int go, input int k);
    return go + 2 + k + (k / IMG_W) * GAP;
  endfunction

  function automatic logic [7:0] patternPix(input int pat, input int a);
    int x;
    int y;
    x = a % IMG_W;
    y = a / IMG_W;
    case (pat)
      0:       return (x < 16) ? 8'd0 : 8'd255;
      1:       return ((x + y) % 2 == 1) ? 8'd255 : 8'd0;
      default: return (x == y) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic clearQueues();
    start_q.delete();
    pix_q.delete();
    pixcyc_q.delete();
    done_q.delete();
    tout_q.delete();
    lerr_q.delete();
  endtask

  task automatic loadFrame(input int pat);
    clearQueues();
    for (int a = 0; a < NPIX; a++) begin
      load_en   = 1'b1;
      load_addr = 10'(a);
      load_data = patternPix(pat, a);
      ref_mem[a] = load_data;
      tick();
    end
    load_en = 1'b0;
    tick();
    checkOutput("idle_load_no_err", lerr_q.size(), 0);
  endtask

  task automatic applyStimulus(input int n_res, input bit spur_go, input bit mid_load,
                               input int rst_pix, input bit go_write);
    int go_cyc;
    int issued;
    int t_exp;
    int rate;
    int delay;
    int load_cyc;
    int limit;
    int d0;
    int hit;
    int bad_data;
    int bad_time;
    int exp_pix;
    int n_pix;
    bit ended;
    bit exp_done;
    clearQueues();
    rate  = $urandom_range(11, 16);
    delay = $urandom_range(0, 20);
    frame_go = 1'b1;
    if (go_write) begin
      load_en    = 1'b1;
      load_addr  = 10'd0;
      load_data  = 8'($urandom_range(1, 254));
      ref_mem[0] = load_data;
    end
    go_cyc = cyc;
    tick();
    frame_go = 1'b0;
    load_en  = 1'b0;
    issued   = 0;
    t_exp    = -1;
    load_cyc = -1;
    ended    = 1'b0;
    limit    = go_cyc + 2 + STREAM_LEN + DRAIN_TIMEOUT + 40;
    while (!ended && cyc < limit) begin
      result_valid = (issued < n_res) && (cyc >= go_cyc + 2 + delay) && ($urandom_range(1, 16) <= rate);
      if (result_valid) begin
        issued++;
        if (issued == EXP_RES) t_exp = cyc;
      end
      frame_go = spur_go && (cyc >= go_cyc + 3) && (cyc <= go_cyc + 2 + STREAM_LEN) && ($urandom_range(0, 19) == 0);
      if (mid_load && cyc == go_cyc + 102) begin
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 8'hAA;
        load_cyc  = cyc;
      end else begin
        load_en = 1'b0;
      end
      if (rst_pix >= 0 && cyc == go_cyc + 2 + rst_pix) begin
        result_valid = 1'b0;
        frame_go     = 1'b0;
        load_en      = 1'b0;
        rst          = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("reset_mid_outputs", outVec(), 32'd0);
        repeat (40) tick();
        exp_pix = 0;
        for (int k = 0; k < NPIX; k++) begin
          if (pixCycle(go_cyc, k) <= go_cyc + 2 + rst_pix) exp_pix++;
        end
        checkOutput("abort_pix_count", pix_q.size(), exp_pix);
        checkOutput("abort_no_done", done_q.size(), 0);
        checkOutput("abort_no_timeout", tout_q.size(), 0);
        checkOutput("abort_busy", busy, 0);
        return;
      end
      tick();
      ended = (done_q.size() > 0) || (tout_q.size() > 0);
    end
    result_valid = 1'b0;
    frame_go     = 1'b0;
    load_en      = 1'b0;
    checkOutput("frame_end_in_budget", ended, 1);
    repeat (3) tick();

    checkOutput("start_count", start_q.size(), 1);
    checkOutput("start_cycle", (start_q.size() > 0) ? start_q[0] : -1, go_cyc + 1);
    checkOutput("pix_count", pix_q.size(), NPIX);
    n_pix = (pix_q.size() < NPIX) ? pix_q.size() : NPIX;
    bad_data = 0;
    bad_time = 0;
    for (int k = 0; k < n_pix; k++) begin
      if (pix_q[k] !== ref_mem[k]) bad_data++;
      if (pixcyc_q[k] != pixCycle(go_cyc, k)) bad_time++;
    end
    checkOutput("pix_data_errors", bad_data, 0);
    checkOutput("pix_timing_errors", bad_time, 0);
    checkOutput("pix5_value", (n_pix > 5) ? 32'(pix_q[5]) : 32'hFFFF_FFFF, 32'(ref_mem[5]));
    checkOutput("stream_span", (n_pix > 0) ? pixcyc_q[n_pix - 1] - pixcyc_q[0] + 1 : 0, STREAM_LEN);

    d0  = go_cyc + 2 + STREAM_LEN;
    hit = (t_exp + 1 > d0) ? t_exp + 1 : d0;
    exp_done = (t_exp >= 0) && (hit <= d0 + DRAIN_TIMEOUT - 1);
    checkOutput("done_count", done_q.size(), exp_done ? 1 : 0);
    checkOutput("timeout_count", tout_q.size(), exp_done ? 0 : 1);
    if (exp_done) begin
      checkOutput("done_cycle", (done_q.size() > 0) ? done_q[0] : -1, hit + 1);
    end else begin
      checkOutput("timeout_cycle", (tout_q.size() > 0) ? tout_q[0] : -1, d0 + DRAIN_TIMEOUT - 1);
    end
    checkOutput("result_cnt_final", result_cnt, issued);
    checkOutput("busy_after", busy, 0);
    checkOutput("load_err_count", lerr_q.size(), mid_load ? 1 : 0);
    if (mid_load) begin
      checkOutput("load_err_cycle", (lerr_q.size() > 0) ? lerr_q[0] : -1, load_cyc + 1);
    end
    last_res = issued;
  endtask

  initial begin
    rst          = 1'b0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_data    = '0;
    frame_go     = 1'b0;
    result_valid = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", outVec(), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("idle_busy", busy, 0);

    $display("[TB] vertical-edge frame, full result count");
    loadFrame(0);
    applyStimulus(EXP_RES, 1'b0, 1'b0, -1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      result_valid = 1'b1;
      tick();
    end
    result_valid = 1'b0;
    tick();
    checkOutput("idle_results_ignored", result_cnt, last_res);

    $display("[TB] one result short, drain timeout");
    applyStimulus(EXP_RES - 1, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] checkerboard frame with a load during streaming");
    loadFrame(1);
    applyStimulus(EXP_RES, 1'b0, 1'b1, -1, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(EXP_RES, 1'b0, 1'b0, 500, 1'b0);

    $display("[TB] full frame after reset with stray frame_go pulses");
    applyStimulus(EXP_RES, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] diagonal frame with a load on the frame_go cycle");
    loadFrame(2);
    applyStimulus(EXP_RES, 1'b1, 1'b0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
